// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: round-robin two-requester framer driving a start/data/parity/gap serial line
module tx_link_scheduler #(
  parameter int GAP_BITS = 4,
  parameter logic START_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_tick,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       grant0,
  output logic       grant1,
  output logic       serial_out,
  output logic       busy,
  output logic       frame_done,
  output logic       last_src
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, GAP} state_t;
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);
  state_t state, state_nx;
  logic [7:0] data_q, data_nx;
  logic [2:0] bit_cnt, bit_nx;
  logic [3:0] gap_cnt, gap_nx;
  logic so_nx, ls_nx, sel1;
  assign busy = state != IDLE;
  assign sel1 = req1_valid & (~req0_valid | ~last_src);
  // state register; reset aborts any frame in progress and favours req0 on the next tie
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      data_q <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      serial_out <= 1'b0;
      last_src <= 1'b1;
    end else begin
      state <= state_nx;
      data_q <= data_nx;
      bit_cnt <= bit_nx;
      gap_cnt <= gap_nx;
      serial_out <= so_nx;
      last_src <= ls_nx;
    end
  // next state and pulses; everything holds between bit ticks
  always_comb begin
    state_nx = state;
    data_nx = data_q;
    bit_nx = bit_cnt;
    gap_nx = gap_cnt;
    so_nx = serial_out;
    ls_nx = last_src;
    grant0 = 1'b0;
    grant1 = 1'b0;
    frame_done = 1'b0;
    if (bit_tick)
      case (state)
        IDLE: begin
          so_nx = 1'b0;
          if (req0_valid | req1_valid) begin
            state_nx = START;
            data_nx = sel1 ? req1_data : req0_data;
            ls_nx = sel1;
            grant0 = ~sel1;
            grant1 = sel1;
            so_nx = START_LEVEL;
          end
        end
        START: begin
          state_nx = DATA;
          so_nx = data_q[7];
          bit_nx = 3'd7;
        end
        DATA: begin
          state_nx = bit_cnt == 3'd0 ? PARITY : DATA;
          so_nx = bit_cnt == 3'd0 ? ^data_q : data_q[bit_cnt - 3'd1];
          bit_nx = bit_cnt == 3'd0 ? bit_cnt : bit_cnt - 3'd1;
        end
        PARITY: begin
          state_nx = GAP;
          so_nx = 1'b0;
          gap_nx = 4'd1;
        end
        GAP: begin
          so_nx = 1'b0;
          frame_done = gap_cnt >= GAP_LAST;
          state_nx = frame_done ? IDLE : GAP;
          gap_nx = frame_done ? 4'd0 : gap_cnt + 4'd1;
        end
        default: state_nx = IDLE;
      endcase
  end
endmodule

// File: tb/tb_tx_link_scheduler.sv
// tb_tx_link_scheduler: directed vectors and frame sequences for tx_link_scheduler
module tb_tx_link_scheduler;
  logic clk = 0, rst = 1, bit_tick = 0;
  logic req0_valid = 0, req1_valid = 0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic grant0, grant1, serial_out, busy, frame_done, last_src;
  logic g0_s, g1_s, fd_s, so_s, busy_s, ls_s;
  int total = 0, bad = 0;
  typedef struct {
    logic r0v; logic [7:0] r0d; logic r1v; logic [7:0] r1d;
    logic g0; logic g1; logic fd; logic so; logic bsy; logic ls;
  } vec_t;
  vec_t vec [14];

  tx_link_scheduler #(.GAP_BITS(4), .START_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .bit_tick(bit_tick),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .grant0(grant0), .grant1(grant1), .serial_out(serial_out),
    .busy(busy), .frame_done(frame_done), .last_src(last_src)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bit_tick = 1;
    #1;
    g0_s = grant0; g1_s = grant1; fd_s = frame_done;
    @(posedge clk);
    #1;
    bit_tick = 0;
    so_s = serial_out; busy_s = busy; ls_s = last_src;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 1) return 1'b1;
    if (k <= 9) return d[9 - k];
    if (k == 10) return ^d;
    return 1'b0;
  endfunction

  task automatic frame(input logic [7:0] d, input logic src, input int pause_at);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("grant0 k=%0d", k), g0_s, k == 1 && !src);
      chk($sformatf("grant1 k=%0d", k), g1_s, k == 1 && src);
      chk($sformatf("frame_done k=%0d", k), fd_s, k == 14);
      chk($sformatf("serial_out k=%0d d=%h", k, d), so_s, exp_bit(d, k));
      chk($sformatf("busy k=%0d", k), busy_s, k != 14);
      if (k == 1) chk("last_src", ls_s, src);
      if (k == pause_at) begin
        int diff = 0;
        for (int c = 0; c < 1000; c++) begin
          @(posedge clk);
          #1;
          if (serial_out !== so_s || busy !== 1'b1 || grant0 || grant1 || frame_done) diff++;
        end
        chk("hold_1000_stable", diff == 0, 1'b1);
      end
    end
  endtask

  initial begin
    vec[0]  = '{1, 8'hA5, 0, 8'h00, 1, 0, 0, 1, 1, 0};
    vec[1]  = '{1, 8'h5A, 1, 8'hC3, 0, 0, 0, 1, 1, 0};
    vec[2]  = '{0, 8'hFF, 1, 8'hC3, 0, 0, 0, 0, 1, 0};
    vec[3]  = '{1, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 0};
    vec[4]  = '{1, 8'h00, 1, 8'h11, 0, 0, 0, 0, 1, 0};
    vec[5]  = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0};
    vec[6]  = '{1, 8'hFF, 1, 8'hFF, 0, 0, 0, 1, 1, 0};
    vec[7]  = '{0, 8'h00, 1, 8'h00, 0, 0, 0, 0, 1, 0};
    vec[8]  = '{1, 8'hA5, 0, 8'h00, 0, 0, 0, 1, 1, 0};
    vec[9]  = '{0, 8'h00, 1, 8'h00, 0, 0, 0, 0, 1, 0};
    vec[10] = '{1, 8'h00, 1, 8'h00, 0, 0, 0, 0, 1, 0};
    vec[11] = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0};
    vec[12] = '{1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0};
    vec[13] = '{0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0};

    do_reset();
    #1;
    chk("reset serial_out", serial_out, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset last_src", last_src, 1'b1);
    chk("reset grant0", grant0, 1'b0);
    chk("reset grant1", grant1, 1'b0);
    chk("reset frame_done", frame_done, 1'b0);

    req0_valid = 1;
    req0_data = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 0;
    tick();
    chk("dropped req grant0", g0_s, 1'b0);
    chk("dropped req grant1", g1_s, 1'b0);
    chk("dropped req busy", busy_s, 1'b0);

    for (int i = 0; i < 14; i++) begin
      req0_valid = vec[i].r0v; req0_data = vec[i].r0d;
      req1_valid = vec[i].r1v; req1_data = vec[i].r1d;
      tick();
      chk($sformatf("vec%0d grant0", i), g0_s, vec[i].g0);
      chk($sformatf("vec%0d grant1", i), g1_s, vec[i].g1);
      chk($sformatf("vec%0d frame_done", i), fd_s, vec[i].fd);
      chk($sformatf("vec%0d serial_out", i), so_s, vec[i].so);
      chk($sformatf("vec%0d busy", i), busy_s, vec[i].bsy);
      chk($sformatf("vec%0d last_src", i), ls_s, vec[i].ls);
    end
    req0_valid = 0; req1_valid = 0;

    do_reset();
    req0_valid = 1; req0_data = 8'h01;
    req1_valid = 1; req1_data = 8'h80;
    frame(8'h01, 1'b0, 0);
    frame(8'h80, 1'b1, 0);
    req0_valid = 0; req1_valid = 0;

    do_reset();
    req1_valid = 1; req1_data = 8'hFF;
    for (int f = 0; f < 3; f++) frame(8'hFF, 1'b1, 0);
    req1_valid = 0;

    do_reset();
    req0_valid = 1; req0_data = 8'h10;
    tick();
    chk("abort grant0", g0_s, 1'b1);
    req0_valid = 0;
    for (int k = 2; k <= 5; k++) tick();
    chk("abort pre serial_out", so_s, 1'b1);
    chk("abort pre busy", busy_s, 1'b1);
    #2;
    rst = 1;
    #1;
    chk("abort serial_out", serial_out, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort last_src", last_src, 1'b1);
    chk("abort frame_done", frame_done, 1'b0);
    @(negedge clk);
    rst = 0;
    req0_valid = 1; req0_data = 8'h3C;
    frame(8'h3C, 1'b0, 0);
    req0_valid = 0;

    do_reset();
    req0_valid = 1; req0_data = 8'hC6;
    frame(8'hC6, 1'b0, 6);
    req0_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
